// File: rtl/reg_bank_pkg.sv
// Shared helpers for the multi-port register bank:
// address-width calculation and flattened-port slice offsets.
package reg_bank_pkg;

   // Address width for a bank of n entries, never below 1 bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Low bit of port p inside a flattened bus of w-bit fields.
   function automatic int slice_lo(input int p, input int w);
      return p * w;
   endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// One storage entry of the register bank.
// Ports: clk, reset (async, active-high), we, d in; q out.
module reg_bank_entry #(
   parameter int DATA_W        = 32,
   parameter bit NEGEDGE_WRITE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] r_q;

   if (NEGEDGE_WRITE) begin : g_neg
      always_ff @(negedge clk or posedge reset) begin
         if (reset)   r_q <= '0;
         else if (we) r_q <= d;
      end
   end else begin : g_pos
      always_ff @(posedge clk or posedge reset) begin
         if (reset)   r_q <= '0;
         else if (we) r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/reg_bank_multiport.sv
// Multi-port register bank: NUM_WR write / NUM_RD read ports.
// Ports: clk, reset, we, wr_addr, wr_data, rd_addr, conflict_clr in;
// rd_data, data_out, entry_valid, wr_conflict out.
module reg_bank_multiport
   import reg_bank_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int DEPTH         = 32,
   parameter int NUM_WR        = 2,
   parameter int NUM_RD        = 3,
   parameter bit NEGEDGE_WRITE = 1,
   parameter bit BYPASS        = 1,
   parameter bit ZERO_ENTRY0   = 1,
   localparam int AW           = clog2_min1(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [DATA_W*DEPTH-1:0]  data_out,
   output logic [DEPTH-1:0]         entry_valid,
   input  logic                     conflict_clr,
   output logic                     wr_conflict
);

   localparam logic [AW:0]      DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [DEPTH-1:0] VLD_RST = DEPTH'(ZERO_ENTRY0);

   logic              r_rst_seen;
   logic              r_conflict;
   logic [DEPTH-1:0]  r_valid;
   logic [AW-1:0]     w_wa   [NUM_WR];
   logic [DATA_W-1:0] w_wd   [NUM_WR];
   logic [NUM_WR-1:0] w_pok;
   logic [DEPTH-1:0]  w_hit;
   logic [DATA_W-1:0] w_wdat [DEPTH];
   logic [DATA_W-1:0] w_q    [DEPTH];
   logic              w_conf;

   // Set by reset, cleared by the first rising edge after release:
   // blocks the write presented across reset (and any pending
   // falling-edge write when reset lands mid-cycle).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rst_seen <= 1'b1;
      else       r_rst_seen <= 1'b0;
   end

   // A port counts only if enabled, in range and writable.
   always_comb begin
      for (int p = 0; p < NUM_WR; p++) begin
         w_wa[p]  = wr_addr[slice_lo(p, AW) +: AW];
         w_wd[p]  = wr_data[slice_lo(p, DATA_W) +: DATA_W];
         w_pok[p] = we[p] && !r_rst_seen
                 && ({1'b0, w_wa[p]} < DEPTH_L)
                 && !(ZERO_ENTRY0 && w_wa[p] == '0);
      end
   end

   // Ascending scan: the highest-numbered hitting port wins.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         w_hit[e]  = 1'b0;
         w_wdat[e] = '0;
         for (int p = 0; p < NUM_WR; p++) begin
            if (w_pok[p] && w_wa[p] == AW'(e)) begin
               w_hit[e]  = 1'b1;
               w_wdat[e] = w_wd[p];
            end
         end
      end
   end

   always_comb begin
      w_conf = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (w_pok[p] && w_pok[q] && w_wa[p] == w_wa[q])
               w_conf = 1'b1;
         end
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      reg_bank_entry #(
         .DATA_W        (DATA_W),
         .NEGEDGE_WRITE (NEGEDGE_WRITE)
      ) u_ent (
         .clk   (clk),
         .reset (reset),
         .we    (w_hit[e]),
         .d     (w_wdat[e]),
         .q     (w_q[e])
      );
      assign data_out[e*DATA_W +: DATA_W] =
         (ZERO_ENTRY0 && e == 0) ? '0 : w_q[e];
   end

   if (NEGEDGE_WRITE) begin : g_vneg
      always_ff @(negedge clk or posedge reset) begin
         if (reset) r_valid <= VLD_RST;
         else       r_valid <= r_valid | w_hit;
      end
   end else begin : g_vpos
      always_ff @(posedge clk or posedge reset) begin
         if (reset) r_valid <= VLD_RST;
         else       r_valid <= r_valid | w_hit;
      end
   end

   // A new conflict takes priority over a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             r_conflict <= 1'b0;
      else if (w_conf)       r_conflict <= 1'b1;
      else if (conflict_clr) r_conflict <= 1'b0;
   end

   // Bypass only matters for rising-edge storage; data_out never
   // sees it.
   always_comb begin
      logic [AW-1:0]     a;
      logic [DATA_W-1:0] v;
      a = '0;
      v = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         a = rd_addr[slice_lo(r, AW) +: AW];
         v = '0;
         if ({1'b0, a} < DEPTH_L && !(ZERO_ENTRY0 && a == '0)) begin
            v = w_q[a];
            if (!NEGEDGE_WRITE && BYPASS && w_hit[a])
               v = w_wdat[a];
         end
         rd_data[slice_lo(r, DATA_W) +: DATA_W] = v;
      end
   end

   assign entry_valid = r_valid;
   assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_reg_bank_multiport.sv
// Scoreboard bench: one falling-edge bank (A) and two rising-edge
// banks of depth 24, with (B) and without (C) read bypass.
module tb_reg_bank_multiport;

   localparam int DW = 32;
   localparam int NW = 2;
   localparam int NR = 3;
   localparam int AW = 5;
   localparam int DA = 32;
   localparam int DB = 24;

   logic              clk = 1'b0;
   logic              rst_a, rst_b;
   logic [NW-1:0]     we;
   logic [NW*AW-1:0]  wa;
   logic [NW*DW-1:0]  wd;
   logic [NR*AW-1:0]  ra;
   logic              clr;

   logic [NR*DW-1:0]  rd_a, rd_b, rd_c;
   logic [DW*DA-1:0]  do_a;
   logic [DW*DB-1:0]  do_b, do_c;
   logic [DA-1:0]     ev_a;
   logic [DB-1:0]     ev_b, ev_c;
   logic              cf_a, cf_b, cf_c;

   always #5 clk = ~clk;

   reg_bank_multiport u_a (
      .clk(clk), .reset(rst_a), .we(we), .wr_addr(wa),
      .wr_data(wd), .rd_addr(ra), .rd_data(rd_a),
      .data_out(do_a), .entry_valid(ev_a),
      .conflict_clr(clr), .wr_conflict(cf_a)
   );

   reg_bank_multiport #(
      .DEPTH(DB), .NEGEDGE_WRITE(0), .BYPASS(1)
   ) u_b (
      .clk(clk), .reset(rst_b), .we(we), .wr_addr(wa),
      .wr_data(wd), .rd_addr(ra), .rd_data(rd_b),
      .data_out(do_b), .entry_valid(ev_b),
      .conflict_clr(clr), .wr_conflict(cf_b)
   );

   reg_bank_multiport #(
      .DEPTH(DB), .NEGEDGE_WRITE(0), .BYPASS(0)
   ) u_c (
      .clk(clk), .reset(rst_b), .we(we), .wr_addr(wa),
      .wr_data(wd), .rd_addr(ra), .rd_data(rd_c),
      .data_out(do_c), .entry_valid(ev_c),
      .conflict_clr(clr), .wr_conflict(cf_c)
   );

   typedef struct {
      logic [NR*DW-1:0] rd;
      logic [NR*DW-1:0] rd2;
      logic [DA*DW-1:0] dout;
      logic [DA-1:0]    ev;
      logic             cf;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   // Reference model state
   logic [DW-1:0] ma [DA];
   logic [DW-1:0] mb [DB];
   logic [DA-1:0] va;
   logic [DB-1:0] vb;
   logic          ca, cb;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int idx,
                      input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   function automatic int wad(input int p);
      return int'(wa[p*AW +: AW]);
   endfunction

   function automatic int rad(input int r);
      return int'(ra[r*AW +: AW]);
   endfunction

   // Writable, in-range entries hit by enabled ports.
   function automatic logic [31:0] hitmap(input int d);
      logic [31:0] h;
      h = '0;
      for (int p = 0; p < NW; p++)
         if (we[p] && wad(p) < d && wad(p) != 0) h[wad(p)] = 1'b1;
      return h;
   endfunction

   function automatic logic [DW-1:0] windata(input int e);
      logic [DW-1:0] v;
      v = '0;
      for (int p = 0; p < NW; p++)
         if (we[p] && wad(p) == e) v = wd[p*DW +: DW];
      return v;
   endfunction

   function automatic logic conflict(input int d);
      int n [32];
      for (int e = 0; e < 32; e++) n[e] = 0;
      for (int p = 0; p < NW; p++)
         if (we[p] && wad(p) < d && wad(p) != 0) n[wad(p)]++;
      for (int e = 0; e < 32; e++)
         if (n[e] >= 2) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input logic [NW-1:0]    s_we,
                       input logic [NW*AW-1:0] s_wa,
                       input logic [NW*DW-1:0] s_wd,
                       input logic [NR*AW-1:0] s_ra,
                       input logic             s_clr,
                       input bit               s_rst);
      exp_t        ea, eb;
      logic [31:0] hm;
      int          a;
      @(posedge clk);
      #1;
      we = s_we; wa = s_wa; wd = s_wd; ra = s_ra; clr = s_clr;
      // Bank A: stored at the coming falling edge, checked after it
      if (s_rst) begin
         for (int e = 0; e < DA; e++) ma[e] = '0;
         va = DA'(1);
         ca = 1'b0;
      end else begin
         hm = hitmap(DA);
         for (int e = 0; e < DA; e++)
            if (hm[e]) begin ma[e] = windata(e); va[e] = 1'b1; end
      end
      ea.rd = '0; ea.rd2 = '0; ea.dout = '0;
      for (int r = 0; r < NR; r++) begin
         a = rad(r);
         ea.rd[r*DW +: DW] = (a < DA) ? ma[a] : '0;
      end
      for (int e = 0; e < DA; e++) ea.dout[e*DW +: DW] = ma[e];
      ea.ev = va;
      ea.cf = ca;
      qa.push_back(ea);
      if (!s_rst) ca = conflict(DA) | (ca & !s_clr);
      // Banks B/C: checked before the rising edge that stores
      hm = hitmap(DB);
      eb.rd = '0; eb.rd2 = '0; eb.dout = '0;
      for (int r = 0; r < NR; r++) begin
         a = rad(r);
         if (a < DB) begin
            eb.rd2[r*DW +: DW] = mb[a];
            eb.rd[r*DW +: DW]  = hm[a] ? windata(a) : mb[a];
         end
      end
      for (int e = 0; e < DB; e++) eb.dout[e*DW +: DW] = mb[e];
      eb.ev = DA'(vb);
      eb.cf = cb;
      qb.push_back(eb);
      for (int e = 0; e < DB; e++)
         if (hm[e]) begin mb[e] = windata(e); vb[e] = 1'b1; end
      cb = conflict(DB) | (cb & !s_clr);
      if (s_rst) begin
         #1 rst_a = 1'b1;
         @(negedge clk);
         #1 rst_a = 1'b0;
      end
   endtask

   function automatic logic [NW*AW-1:0] wa2(input int a0, input int a1);
      return {AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [NR*AW-1:0] ra3(input int a0, input int a1,
                                            input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [NW*DW-1:0] wd2(input logic [DW-1:0] d0,
                                            input logic [DW-1:0] d1);
      return {d1, d0};
   endfunction

   // Monitor A: after the falling edge, before the next rising edge
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (qa.size() > 0) begin
            x = qa.pop_front();
            for (int r = 0; r < NR; r++)
               chk("a_rd", r, rd_a[r*DW +: DW], x.rd[r*DW +: DW]);
            for (int e = 0; e < DA; e++)
               chk("a_dout", e, do_a[e*DW +: DW], x.dout[e*DW +: DW]);
            chk("a_valid", 0, ev_a, x.ev);
            chk("a_conf", 0, 32'(cf_a), 32'(x.cf));
         end
      end
   end

   // Monitor B/C: late in the cycle, before the storing rising edge
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #4;
         if (qb.size() > 0) begin
            x = qb.pop_front();
            for (int r = 0; r < NR; r++) begin
               chk("b_rd", r, rd_b[r*DW +: DW], x.rd[r*DW +: DW]);
               chk("c_rd", r, rd_c[r*DW +: DW], x.rd2[r*DW +: DW]);
            end
            for (int e = 0; e < DB; e++) begin
               chk("b_dout", e, do_b[e*DW +: DW], x.dout[e*DW +: DW]);
               chk("c_dout", e, do_c[e*DW +: DW], x.dout[e*DW +: DW]);
            end
            chk("b_valid", 0, 32'(ev_b), 32'(x.ev[DB-1:0]));
            chk("c_valid", 0, 32'(ev_c), 32'(x.ev[DB-1:0]));
            chk("b_conf", 0, 32'(cf_b), 32'(x.cf));
            chk("c_conf", 0, 32'(cf_c), 32'(x.cf));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NW*AW-1:0] rwa;
      logic [NW*DW-1:0] rwd;
      logic [NR*AW-1:0] rra;
      int               k;
      we = '0; wa = '0; wd = '0; ra = '0; clr = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      for (int e = 0; e < DA; e++) ma[e] = '0;
      for (int e = 0; e < DB; e++) mb[e] = '0;
      va = DA'(1); vb = DB'(1); ca = 1'b0; cb = 1'b0;
      #1 rst_a = 1'b1; rst_b = 1'b1;
      #2 rst_a = 1'b0; rst_b = 1'b0;

      step('0, '0, '0, ra3(0, 5, 7), 1'b0, 0);
      step(2'b01, wa2(5, 0), wd2(32'hDEADBEEF, 32'h0),
           ra3(5, 0, 0), 1'b0, 0);
      step(2'b11, wa2(7, 7), wd2(32'h11111111, 32'h22222222),
           ra3(7, 5, 0), 1'b0, 0);
      step('0, '0, '0, ra3(7, 5, 0), 1'b1, 0);
      step('0, '0, '0, ra3(7, 0, 0), 1'b0, 0);
      step(2'b11, wa2(0, 0), wd2(32'hFFFFFFFF, 32'hFFFFFFFF),
           ra3(0, 0, 0), 1'b0, 0);
      step('0, '0, '0, ra3(0, 7, 5), 1'b0, 0);
      step(2'b01, wa2(3, 0), wd2(32'hA5A5A5A5, 32'h0),
           ra3(3, 3, 3), 1'b0, 0);
      step(2'b01, wa2(30, 0), wd2(32'h12345678, 32'h0),
           ra3(30, 3, 0), 1'b0, 0);
      step(2'b11, wa2(7, 7), wd2(32'h33333333, 32'h44444444),
           ra3(7, 30, 0), 1'b1, 0);
      step('0, '0, '0, ra3(7, 30, 0), 1'b0, 0);
      step(2'b01, wa2(9, 0), wd2(32'hCAFEF00D, 32'h0),
           ra3(9, 5, 0), 1'b0, 1);
      step('0, '0, '0, ra3(9, 5, 7), 1'b0, 0);

      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < NW; p++) begin
            if ($urandom_range(0, 2) == 0)
               rwa[p*AW +: AW] = AW'($urandom_range(0, 3));
            else
               rwa[p*AW +: AW] = AW'($urandom_range(0, 31));
            rwd[p*DW +: DW] = $urandom;
         end
         for (int r = 0; r < NR; r++) begin
            k = int'($urandom_range(0, NW - 1));
            if ($urandom_range(0, 1) == 0)
               rra[r*AW +: AW] = rwa[k*AW +: AW];
            else
               rra[r*AW +: AW] = AW'($urandom_range(0, 31));
         end
         step(NW'($urandom), rwa, rwd, rra,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 49) == 0);
      end

      repeat (3) @(posedge clk);
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d/%0d want=0/0",
                  qa.size(), qb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
